// File: rtl/lsu_bus_ctrl.sv
// LSU memory-side bus controller: one valid/ready request plus one response per load/store, stalling the pipeline throughout.
// Optional bus timeout is compiled in with `define LSU_BUS_TIMEOUT_EN.
module lsu_bus_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lsu_req,
  input  logic              i_lsu_we,
  input  logic [ADDR_W-1:0] i_lsu_addr,
  input  logic [31:0]       i_lsu_wdata,
  input  logic [3:0]        i_lsu_strb,
  output logic              o_lsu_stall,
  output logic              o_lsu_done,
  output logic [31:0]       o_lsu_rdata,
  output logic              o_lsu_err,
  output logic              o_bus_valid,
  input  logic              i_bus_ready,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [31:0]       o_bus_wdata,
  output logic [3:0]        o_bus_strb,
  input  logic              i_bus_rvalid,
  input  logic [31:0]       i_bus_rdata,
  input  logic              i_bus_rerr
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t            state_reg, state_next;
  logic              bus_we_reg, bus_we_next;
  logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
  logic [31:0]       bus_wdata_reg, bus_wdata_next;
  logic [3:0]        bus_strb_reg, bus_strb_next;
  logic [31:0]       lsu_rdata_reg, lsu_rdata_next;
  logic              lsu_err_reg, lsu_err_next;
  logic [31:0]       req_wdata;
  logic [3:0]        req_strb;
  logic              tmo_hit;

  // Loads put no data and no strobe on the bus.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign req_wdata[8*gi +: 8] = i_lsu_we ? i_lsu_wdata[8*gi +: 8] : 8'h00;
      assign req_strb[gi]         = i_lsu_we & i_lsu_strb[gi];
    end
  endgenerate

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;

  always_comb begin
    tmo_cnt_next = tmo_cnt_reg;
    if (state_reg == IDLE && i_lsu_req) begin
      tmo_cnt_next = '0;
    end else if (state_reg == REQ || state_reg == RESP) begin
      tmo_cnt_next = tmo_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
    end
  end

  assign tmo_hit = (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;

  // Keeps the parameter referenced when the timeout logic is not built.
  if (TIMEOUT_CYCLES < 2) begin : g_tmo_unused
  end
`endif

  always_comb begin
    state_next     = state_reg;
    bus_we_next    = bus_we_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;
    bus_strb_next  = bus_strb_reg;
    lsu_rdata_next = lsu_rdata_reg;
    lsu_err_next   = lsu_err_reg;
    case (state_reg)
      IDLE: begin
        if (i_lsu_req) begin
          state_next     = REQ;
          bus_we_next    = i_lsu_we;
          bus_addr_next  = i_lsu_addr & ~ADDR_W'(3);
          bus_wdata_next = req_wdata;
          bus_strb_next  = req_strb;
        end
      end
      REQ: begin
        if (i_bus_ready) begin
          state_next = RESP;
        end else if (tmo_hit) begin
          state_next     = DONE;
          lsu_rdata_next = 32'h0;
          lsu_err_next   = 1'b1;
        end
      end
      RESP: begin
        if (i_bus_rvalid) begin
          state_next     = DONE;
          lsu_rdata_next = bus_we_reg ? 32'h0 : i_bus_rdata;
          lsu_err_next   = i_bus_rerr;
        end else if (tmo_hit) begin
          state_next     = DONE;
          lsu_rdata_next = 32'h0;
          lsu_err_next   = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= 32'h0;
      bus_strb_reg  <= 4'h0;
      lsu_rdata_reg <= 32'h0;
      lsu_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bus_we_reg    <= bus_we_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
      bus_strb_reg  <= bus_strb_next;
      lsu_rdata_reg <= lsu_rdata_next;
      lsu_err_reg   <= lsu_err_next;
    end
  end

  // Stall drops in DONE so the pipeline advances on the completing edge.
  assign o_lsu_stall = (state_reg == IDLE && i_lsu_req) || state_reg == REQ || state_reg == RESP;
  assign o_lsu_done  = (state_reg == DONE);
  assign o_lsu_rdata = lsu_rdata_reg;
  assign o_lsu_err   = lsu_err_reg;
  assign o_bus_valid = (state_reg == REQ);
  assign o_bus_we    = bus_we_reg;
  assign o_bus_addr  = bus_addr_reg;
  assign o_bus_wdata = bus_wdata_reg;
  assign o_bus_strb  = bus_strb_reg;

endmodule
